// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO; frame format set by DATA_BITS/PARITY/STOP_BITS.
// Bit timing comes from an external baud_gen via tx_baud_en / tx_count_baud_ready.
module uart_tx_fifo #(
  parameter int unsigned freq       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] d_in,
  input  logic                 tx_en,
  input  logic                 tx_count_baud_ready,
  output logic                 tx_baud_en,
  output logic                 seri_out,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 overflow
);

  localparam int unsigned CntW     = ADDR_W + 1;
  localparam logic [2:0]  LastBit  = 3'(DATA_BITS - 1);
  localparam logic        LastStop = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || FIFO_DEPTH != (1 << ADDR_W) || freq == 0) begin : g_bad_params
    $error("uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_q, par_d;
  logic                  seri_q, seri_d;
  logic                  baud_en_q, baud_en_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic                  push, pop;
  logic [DATA_BITS-1:0]  head;

  always_comb begin
    push       = tx_en && !full_q;
    pop        = 1'b0;
    head       = mem_q[rd_ptr_q];
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    seri_d     = seri_q;
    baud_en_d  = baud_en_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    overflow_d = tx_en && full_q;

    unique case (state_q)
      StIdle: begin
        seri_d    = 1'b1;
        baud_en_d = 1'b0;
        if (!empty_q) begin
          pop       = 1'b1;
          shift_d   = head;
          bit_cnt_d = 3'd0;
          // Parity latched from the byte as popped, before any shifting.
          par_d     = (^head) ^ (PARITY == 2);
          state_d   = StStart;
          start_d   = 1'b1;
          busy_d    = 1'b1;
          seri_d    = 1'b0;
          baud_en_d = 1'b1;
        end
      end
      StStart: begin
        if (tx_count_baud_ready) begin
          seri_d  = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (tx_count_baud_ready) begin
          if (bit_cnt_q == LastBit) begin
            stop_cnt_d = 1'b0;
            if (PARITY != 0) begin
              seri_d  = par_q;
              state_d = StPar;
            end else begin
              seri_d  = 1'b1;
              state_d = StStop;
            end
          end else begin
            shift_d   = shift_q >> 1;
            seri_d    = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StPar: begin
        if (tx_count_baud_ready) begin
          seri_d     = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (tx_count_baud_ready) begin
          if (stop_cnt_q == LastStop) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            baud_en_d = 1'b0;
            state_d   = StIdle;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    full_d   = (count_d == CntW'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      seri_q     <= 1'b1;
      baud_en_q  <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      seri_q     <= seri_d;
      baud_en_q  <= baud_en_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
    end
  end

  assign tx_baud_en = baud_en_q;
  assign seri_out   = seri_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fifo_full  = full_q;
  assign fifo_empty = empty_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 8E2, 8O1 and 5N1 framing.
// A simple baud model ticks every Div clocks while tx_baud_en is high.
module tb_uart_tx_fifo;
  localparam int Div = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] tx_en, tick, baud_en, seri, start, busy, done, full, empty, ovf;
  logic [7:0] din0, din1, din2;
  logic [4:0] din3;
  int checks = 0;
  int failures = 0;
  int bcnt [4];
  int start_cnt [4];
  int done_cnt [4];

  uart_tx_fifo u_dut0 (
    .clk(clk), .rst(rst), .d_in(din0), .tx_en(tx_en[0]), .tx_count_baud_ready(tick[0]),
    .tx_baud_en(baud_en[0]), .seri_out(seri[0]), .start(start[0]), .busy(busy[0]),
    .done(done[0]), .fifo_full(full[0]), .fifo_empty(empty[0]), .overflow(ovf[0])
  );
  uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .d_in(din1), .tx_en(tx_en[1]), .tx_count_baud_ready(tick[1]),
    .tx_baud_en(baud_en[1]), .seri_out(seri[1]), .start(start[1]), .busy(busy[1]),
    .done(done[1]), .fifo_full(full[1]), .fifo_empty(empty[1]), .overflow(ovf[1])
  );
  uart_tx_fifo #(.PARITY(2)) u_dut2 (
    .clk(clk), .rst(rst), .d_in(din2), .tx_en(tx_en[2]), .tx_count_baud_ready(tick[2]),
    .tx_baud_en(baud_en[2]), .seri_out(seri[2]), .start(start[2]), .busy(busy[2]),
    .done(done[2]), .fifo_full(full[2]), .fifo_empty(empty[2]), .overflow(ovf[2])
  );
  uart_tx_fifo #(.DATA_BITS(5)) u_dut3 (
    .clk(clk), .rst(rst), .d_in(din3), .tx_en(tx_en[3]), .tx_count_baud_ready(tick[3]),
    .tx_baud_en(baud_en[3]), .seri_out(seri[3]), .start(start[3]), .busy(busy[3]),
    .done(done[3]), .fifo_full(full[3]), .fifo_empty(empty[3]), .overflow(ovf[3])
  );

  // Baud model: counter held at zero while disabled, like baud_gen.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!baud_en[i] || bcnt[i] == Div - 1) bcnt[i] <= 0;
      else bcnt[i] <= bcnt[i] + 1;
      if (start[i] === 1'b1) start_cnt[i] <= start_cnt[i] + 1;
      if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  always_comb begin
    tick = '0;
    for (int i = 0; i < 4; i++) tick[i] = baud_en[i] && (bcnt[i] == Div - 1);
  end

  task automatic push(input int i, input logic [7:0] d);
    case (i)
      0: din0 = d;
      1: din1 = d;
      2: din2 = d;
      default: din3 = d[4:0];
    endcase
    tx_en[i] = 1'b1;
    @(negedge clk);
    tx_en[i] = 1'b0;
  endtask

  task automatic wait_start(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (start[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int i, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (done[i] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Called on the negedge where start is high; returns on the negedge after busy falls.
  task automatic capture(input int i, output logic [15:0] bits, output int blen);
    bits = '0;
    blen = 0;
    for (int c = 0; c < 2000; c++) begin
      if (busy[i] !== 1'b1) break;
      if (c % Div == Div / 2 && c / Div < 16) bits[c / Div] = seri[i];
      blen++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (seri[0] !== 1'b1) begin failures++; $display("FAIL reset_seri got=%b exp=1", seri[0]); end
    checks++; if (baud_en[0] !== 1'b0) begin failures++; $display("FAIL reset_baud_en got=%b exp=0", baud_en[0]); end
    checks++; if (start[0] !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
    checks++; if (done[0] !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done[0]); end
    checks++; if (ovf[0] !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", ovf[0]); end
    checks++; if (empty !== 4'hF) begin failures++; $display("FAIL reset_empty got=%b exp=1111", empty); end
    checks++; if (full !== 4'h0) begin failures++; $display("FAIL reset_full got=%b exp=0000", full); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (seri !== 4'hF) begin failures++; $display("FAIL idle_seri got=%b exp=1111", seri); end
  endtask

  task automatic test_single_frame();
    logic [15:0] bits;
    int blen, s0, d0;
    bit ok;
    s0 = start_cnt[0];
    d0 = done_cnt[0];
    push(0, 8'hA5);
    checks++; if (empty[0] !== 1'b0) begin failures++; $display("FAIL single_empty_after_push got=%b exp=0", empty[0]); end
    wait_start(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_start_timeout got=0 exp=1"); end
    checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL single_empty_on_pop got=%b exp=1", empty[0]); end
    checks++; if (busy[0] !== 1'b1 || seri[0] !== 1'b0) begin failures++; $display("FAIL single_start_line got=busy%b/seri%b exp=busy1/seri0", busy[0], seri[0]); end
    capture(0, bits, blen);
    checks++; if (bits[9:0] !== 10'b1101001010) begin failures++; $display("FAIL single_bits got=%b exp=1101001010", bits[9:0]); end
    checks++; if (blen != 10 * Div) begin failures++; $display("FAIL single_busy_len got=%0d exp=%0d", blen, 10 * Div); end
    checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", done[0]); end
    @(negedge clk);
    checks++; if (start_cnt[0] - s0 != 1 || done_cnt[0] - d0 != 1) begin failures++; $display("FAIL single_pulse_counts got=start%0d/done%0d exp=1/1", start_cnt[0] - s0, done_cnt[0] - d0); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_frames [4];
    logic [15:0] bits;
    int blen;
    bit ok;
    exp_frames[0] = 10'h202;
    exp_frames[1] = 10'h204;
    exp_frames[2] = 10'h206;
    exp_frames[3] = 10'h208;
    push(0, 8'hF0);
    wait_start(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_lead_start_timeout got=0 exp=1"); end
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    checks++; if (full[0] !== 1'b0) begin failures++; $display("FAIL b2b_full_after3 got=%b exp=0", full[0]); end
    push(0, 8'h04);
    checks++; if (full[0] !== 1'b1) begin failures++; $display("FAIL b2b_full_after4 got=%b exp=1", full[0]); end
    wait_done(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_lead_done_timeout got=0 exp=1"); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (start[0] !== 1'b1) begin failures++; $display("FAIL b2b_gap_%0d got=start%b exp=start1", k, start[0]); end
      if (k == 0) begin
        checks++; if (full[0] !== 1'b0) begin failures++; $display("FAIL b2b_full_drop got=%b exp=0", full[0]); end
      end
      capture(0, bits, blen);
      checks++; if (bits[9:0] !== exp_frames[k]) begin failures++; $display("FAIL b2b_frame_%0d got=%h exp=%h", k, bits[9:0], exp_frames[k]); end
      checks++; if (done[0] !== 1'b1) begin failures++; $display("FAIL b2b_done_%0d got=%b exp=1", k, done[0]); end
    end
    @(negedge clk);
    checks++; if (empty[0] !== 1'b1 || start[0] !== 1'b0) begin failures++; $display("FAIL b2b_drained got=empty%b/start%b exp=empty1/start0", empty[0], start[0]); end
  endtask

  task automatic test_overflow();
    logic [9:0] exp_frames [4];
    logic [15:0] bits;
    int blen;
    bit ok, extra;
    exp_frames[0] = 10'h224;
    exp_frames[1] = 10'h226;
    exp_frames[2] = 10'h228;
    exp_frames[3] = 10'h22A;
    for (int k = 0; k < 5; k++) begin
      push(0, 8'h11 + 8'(k));
      checks++; if (ovf[0] !== 1'b0) begin failures++; $display("FAIL ovf_early_%0d got=%b exp=0", k, ovf[0]); end
    end
    checks++; if (full[0] !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full[0]); end
    push(0, 8'h16);
    checks++; if (ovf[0] !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ovf[0]); end
    @(negedge clk);
    checks++; if (ovf[0] !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", ovf[0]); end
    wait_done(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_first_done_timeout got=0 exp=1"); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      capture(0, bits, blen);
      checks++; if (bits[9:0] !== exp_frames[k]) begin failures++; $display("FAIL ovf_frame_%0d got=%h exp=%h", k, bits[9:0], exp_frames[k]); end
    end
    extra = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (start[0] === 1'b1) extra = 1'b1;
    end
    checks++; if (extra) begin failures++; $display("FAIL ovf_dropped_sent got=start exp=none"); end
  endtask

  task automatic test_parity_stop();
    logic [15:0] bits;
    int blen;
    bit ok;
    push(1, 8'h07);
    wait_start(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL even_start_timeout got=0 exp=1"); end
    capture(1, bits, blen);
    checks++; if (bits[11:0] !== 12'hE0E) begin failures++; $display("FAIL even_bits got=%h exp=e0e", bits[11:0]); end
    checks++; if (blen != 12 * Div) begin failures++; $display("FAIL even_len got=%0d exp=%0d", blen, 12 * Div); end
    push(2, 8'h03);
    wait_start(2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL odd_start_timeout got=0 exp=1"); end
    capture(2, bits, blen);
    checks++; if (bits[10:0] !== 11'h606) begin failures++; $display("FAIL odd_bits got=%h exp=606", bits[10:0]); end
    checks++; if (blen != 11 * Div) begin failures++; $display("FAIL odd_len got=%0d exp=%0d", blen, 11 * Div); end
  endtask

  task automatic test_data5();
    logic [15:0] bits;
    int blen;
    bit ok;
    push(3, 8'h1E);
    wait_start(3, ok);
    checks++; if (!ok) begin failures++; $display("FAIL d5_start_timeout got=0 exp=1"); end
    capture(3, bits, blen);
    checks++; if (bits[6:0] !== 7'h7C) begin failures++; $display("FAIL d5_bits got=%b exp=1111100", bits[6:0]); end
    checks++; if (blen != 7 * Div || done[3] !== 1'b1) begin failures++; $display("FAIL d5_len got=%0d/done%b exp=%0d/done1", blen, done[3], 7 * Div); end
  endtask

  task automatic test_reset_mid_frame();
    bit extra;
    push(0, 8'hFF);
    push(0, 8'hAA);
    push(0, 8'hBB);
    repeat (3 * Div) @(negedge clk);
    checks++; if (busy[0] !== 1'b1 || seri[0] !== 1'b1) begin failures++; $display("FAIL midrst_pre got=busy%b/seri%b exp=busy1/seri1", busy[0], seri[0]); end
    checks++; if (empty[0] !== 1'b0) begin failures++; $display("FAIL midrst_queued got=empty%b exp=empty0", empty[0]); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (seri[0] !== 1'b1 || busy[0] !== 1'b0) begin failures++; $display("FAIL midrst_line got=seri%b/busy%b exp=seri1/busy0", seri[0], busy[0]); end
    checks++; if (empty[0] !== 1'b1 || baud_en[0] !== 1'b0) begin failures++; $display("FAIL midrst_fifo got=empty%b/baud%b exp=empty1/baud0", empty[0], baud_en[0]); end
    extra = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (start[0] === 1'b1 || seri[0] !== 1'b1) extra = 1'b1;
    end
    checks++; if (extra) begin failures++; $display("FAIL midrst_restart got=activity exp=idle"); end
  endtask

  initial begin
    tx_en = '0;
    din0 = '0;
    din1 = '0;
    din2 = '0;
    din3 = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_parity_stop();
    test_data5();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
